quant_result_packer: RTL
========================

# quant_result_packer

Sink for the four-channel quantization stage. Collects the per-channel quantized samples (one per `quant_valid` strobe), packs four samples per channel into 32-bit words, buffers them in per-channel FIFOs, and drains them round-robin onto a single valid/ready stream toward the feature-map write-back DMA. The block frames each layer by the output-map size selected by `conv_compute_mode` and flushes partial words at the end of each frame.

## Interface
- `DATA_W`, 8: quantized sample width; equals `CONV_IN_BIT_WIDTH_F` (integer, 8 in this design).
- `FIFO_DEPTH`, 16: words per channel FIFO; must be a power of 2.
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle pulse. Latches `conv_compute_mode` and `chan_mask`, then clears the counters.
- `conv_compute_mode`  in  2  frame length in samples per channel: 0→576, 1→64, 2→16, 3→1.
- `chan_mask`  in  4  channels that take part in this frame.
- `quant_valid`  in  4  per-channel sample strobe.
- `quant_o_data_c0..c3`  in  DATA_W each  signed quantized samples.
- `m_data`  out  32  packed word.
- `m_chan`  out  2  source channel of `m_data`.
- `m_last`  out  1  final word of that channel for the frame.
- `m_valid`  out  1  output word available.
- `m_ready`  in  1  downstream accepts.
- `busy`  out  1  high from `start` until `done`.
- `done`  out  1  one-cycle pulse when every masked channel's last word has been accepted.
- `overflow_err`  out  4  sticky per channel; set when a word is dropped because the FIFO is full.

## Operation
- **States.**
  - IDLE → RUN on `start`.
  - RUN → DONE when every masked channel has had its `m_last` handshake.
  - DONE → IDLE after 1 cycle. `done` is asserted in DONE.
  - `start` is ignored outside IDLE.
  - `quant_valid` is ignored in IDLE/DONE and on channels not in the latched mask.
- **Per-channel packer.**
  - Byte lane counter runs 0..3. A sample goes to bits `[8*lane+7:8*lane]`, so the first sample sits in `[7:0]`.
  - The sample counter counts up to the frame length N.
  - A word is pushed when the lane reaches 3, or when the sample is sample N (end-of-frame flush). Unused upper lanes are zero in a flushed word. The pushed word carries a last flag.
  - Samples beyond N in the same frame are dropped.
- **FIFO.**
  - One per channel, storing {last, 32-bit word}.
  - A push is accepted if the FIFO is not full, or if a pop happens in the same cycle.
  - Otherwise the word is dropped and `overflow_err[ch]` is set. The last flag is also lost, so `done` never fires; software recovers with reset.
- **Arbiter.**
  - Round-robin over non-empty FIFOs, starting after the last granted channel. The pointer resets to channel 0.
  - While `m_valid && !m_ready`, `m_data`, `m_chan` and `m_last` stay stable and the grant does not change.
  - The pointer advances only on a handshake.
- **Width.** Samples are stored as raw two's-complement bit patterns, with no sign extension within a lane.

## Timing
- **Reset.** Every output resets to 0, and the state returns to IDLE. Reset mid-frame discards all FIFO contents, clears `overflow_err`, and drops the frame.
- **Latency.** A word completed by the sample at cycle t is in the FIFO at t+1. `m_valid` can first be high at t+2, via a registered output stage.
- **Throughput.**
  - The input side is one sample per channel per cycle, all four channels at once.
  - The output side is one word per cycle while `m_ready` stays high.
  - Peak input rate is 4 words per 4 cycles against 1 word per cycle out, so sustained full-rate input on all channels depends on FIFO slack.
- **Frame end.** `busy` is high from the cycle after `start` through the DONE cycle. `done` comes 1 cycle after the last `m_last` handshake.
- **Simultaneous events.**
  - A push and a pop on the same FIFO in the same cycle leave the count unchanged.
  - Completing a word and flushing on the same sample gives a single push.

## Test plan
- **Mode 2 (N=16), mask 4'b0001, 16 samples 0x01..0x10 on ch0, `m_ready`=1:** 4 words 0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D, with `m_chan`=0 and `m_last` only on the 4th word; `done` one cycle after that.
- **Mode 3 (N=1), mask 4'b1111, one sample each with data 0x80, 0x7F, 0xFF, 0x01 on all 4 channels at once:** words 0x00000080, 0x0000007F, 0x000000FF, 0x00000001 in channel order 0,1,2,3, each with `m_last`=1.
- **Mode 1 (N=64), mask 4'b1111, `m_ready` toggling every cycle:** 16 words per channel; grants round-robin; outputs stable during stalls; total 64 handshakes, then `done`.
- **Mode 0 with `m_ready`=0, 80 samples on ch2:** words 1..16 accepted into the FIFO; words 17..20 dropped; `overflow_err`=4'b0100 and stays set.
- **Reset asserted mid-frame after 10 samples:** all outputs 0 on the next cycle. A fresh `start` then runs a clean mode 2 frame with correct packing from lane 0.

Source files
------------

// File: rtl/quant_result_packer_if.sv
// Output word stream of quant_result_packer toward the write-back DMA.
// Latency: n/a (signal bundle only).
// Backpressure: m_ready from the slave holds the master's word stable.
interface quant_result_packer_if;
  logic [31:0] m_data;   // packed word, first sample in [7:0]
  logic [1:0]  m_chan;   // source channel of m_data
  logic        m_last;   // final word of that channel for the frame
  logic        m_valid;  // word available
  logic        m_ready;  // downstream accepts

  modport master (output m_data, m_chan, m_last, m_valid, input m_ready);
  modport slave  (input m_data, m_chan, m_last, m_valid, output m_ready);
endinterface

// File: rtl/quant_result_packer.sv
// Packs 4 quantized samples per channel into 32-bit words, buffers them per channel, drains round-robin.
// Latency: word in FIFO one cycle after its completing sample, on m_valid one cycle later (registered out).
// Backpressure: m_ready low holds the output word; full FIFOs drop words and set sticky overflow_err.
// Ports: clk, rst_n (sync, active low), start/conv_compute_mode/chan_mask frame setup,
//        quant_valid + quant_o_data_c0..c3 sample input, m_if output stream, busy/done/overflow_err status.
module quant_result_packer #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        conv_compute_mode,
  input  logic [3:0]        chan_mask,
  input  logic [3:0]        quant_valid,
  input  logic [DATA_W-1:0] quant_o_data_c0,
  input  logic [DATA_W-1:0] quant_o_data_c1,
  input  logic [DATA_W-1:0] quant_o_data_c2,
  input  logic [DATA_W-1:0] quant_o_data_c3,
  quant_result_packer_if.master m_if,
  output logic              busy,
  output logic              done,
  output logic [3:0]        overflow_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW-1:0] PTR_ONE = 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  mode_q;
  logic [3:0]  mask_q;
  logic [3:0]  last_seen;
  logic [9:0]  frame_len;
  logic        start_acc;

  logic [DATA_W-1:0] samp [4];
  logic [1:0]  lane [4];
  logic [9:0]  cnt  [4];
  logic [31:0] acc  [4];

  logic [32:0]   mem   [4][FIFO_DEPTH];
  logic [AW-1:0] wptr  [4];
  logic [AW-1:0] rptr  [4];
  logic [AW:0]   count [4];

  logic [3:0]  take, push, push_ok, pop, full, inflight, hs_ch, hs_last;
  logic [31:0] word  [4];
  logic [3:0]  wlast;

  logic        out_vld, out_last, load, hs;
  logic [31:0] out_dat;
  logic [1:0]  out_chan, rr_ptr, grant, idx;
  logic        grant_vld;
  logic [32:0] head;

  assign samp[0] = quant_o_data_c0;
  assign samp[1] = quant_o_data_c1;
  assign samp[2] = quant_o_data_c2;
  assign samp[3] = quant_o_data_c3;

  assign start_acc = (state == ST_IDLE) && start;
  assign hs        = out_vld && m_if.m_ready;
  assign load      = !out_vld || m_if.m_ready;

  always_comb begin
    frame_len = 10'd576;
    case (mode_q)
      2'd0: frame_len = 10'd576;
      2'd1: frame_len = 10'd64;
      2'd2: frame_len = 10'd16;
      default: frame_len = 10'd1;
    endcase
  end

  // Packer and FIFO admission. A word held in the output register still
  // counts against its channel's capacity, so each channel buffers exactly
  // FIFO_DEPTH words in total; its own handshake frees a slot in the same cycle.
  always_comb begin
    take = '0; push = '0; push_ok = '0; full = '0; inflight = '0;
    hs_ch = '0; hs_last = '0; wlast = '0;
    for (int ch = 0; ch < 4; ch++) begin
      word[ch]     = acc[ch] | ({{(32-DATA_W){1'b0}}, samp[ch]} << (DATA_W * int'(lane[ch])));
      take[ch]     = (state == ST_RUN) && mask_q[ch] && quant_valid[ch] && (cnt[ch] != frame_len);
      wlast[ch]    = (cnt[ch] + 10'd1) == frame_len;
      push[ch]     = take[ch] && ((lane[ch] == 2'd3) || wlast[ch]);
      inflight[ch] = out_vld && (out_chan == 2'(ch));
      hs_ch[ch]    = hs && (out_chan == 2'(ch));
      hs_last[ch]  = hs_ch[ch] && out_last;
      full[ch]     = (int'(count[ch]) + int'(inflight[ch])) >= FIFO_DEPTH;
      push_ok[ch]  = push[ch] && (!full[ch] || hs_ch[ch]);
    end
  end

  // Round-robin: rr_ptr is the first channel considered on the next load.
  always_comb begin
    grant_vld = 1'b0;
    grant     = 2'd0;
    idx       = 2'd0;
    pop       = '0;
    for (int i = 0; i < 4; i++) begin
      idx = rr_ptr + 2'(i);
      if (!grant_vld && (count[idx] != '0)) begin
        grant_vld = 1'b1;
        grant     = idx;
      end
    end
    if (load && grant_vld) pop[grant] = 1'b1;
    head = mem[grant][rptr[grant]];
  end

  // FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mode_q    <= 2'd0;
      mask_q    <= 4'd0;
      last_seen <= 4'd0;
    end else begin
      state <= state_nxt;
      if (start_acc) begin
        mode_q    <= conv_compute_mode;
        mask_q    <= chan_mask;
        last_seen <= 4'd0;
      end else begin
        last_seen <= last_seen | hs_last;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN: begin
        busy = 1'b1;
        // include this cycle's handshake so done follows the last one by a cycle
        if ((last_seen | hs_last | ~mask_q) == 4'hF) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Lane/sample counters and partial-word accumulators
  always_ff @(posedge clk) begin
    for (int ch = 0; ch < 4; ch++) begin
      if (!rst_n || start_acc) begin
        lane[ch] <= 2'd0;
        cnt[ch]  <= 10'd0;
        acc[ch]  <= 32'd0;
      end else if (take[ch]) begin
        lane[ch] <= lane[ch] + 2'd1;
        cnt[ch]  <= cnt[ch] + 10'd1;
        acc[ch]  <= push[ch] ? 32'd0 : word[ch];
      end
    end
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    for (int ch = 0; ch < 4; ch++) begin
      if (!rst_n) begin
        wptr[ch]         <= '0;
        rptr[ch]         <= '0;
        count[ch]        <= '0;
        overflow_err[ch] <= 1'b0;
      end else begin
        if (push_ok[ch]) wptr[ch] <= wptr[ch] + PTR_ONE;
        if (pop[ch])     rptr[ch] <= rptr[ch] + PTR_ONE;
        case ({push_ok[ch], pop[ch]})
          2'b10:   count[ch] <= count[ch] + CNT_ONE;
          2'b01:   count[ch] <= count[ch] - CNT_ONE;
          default: count[ch] <= count[ch];
        endcase
        if (push[ch] && !push_ok[ch]) overflow_err[ch] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int ch = 0; ch < 4; ch++) begin
      if (push_ok[ch]) mem[ch][wptr[ch]] <= {wlast[ch], word[ch]};
    end
  end

  // Registered output stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_vld  <= 1'b0;
      out_dat  <= 32'd0;
      out_chan <= 2'd0;
      out_last <= 1'b0;
      rr_ptr   <= 2'd0;
    end else begin
      if (load) begin
        out_vld <= grant_vld;
        if (grant_vld) begin
          out_dat  <= head[31:0];
          out_last <= head[32];
          out_chan <= grant;
          rr_ptr   <= grant + 2'd1;
        end
      end
      if (start_acc) rr_ptr <= 2'd0;
    end
  end

  assign m_if.m_data  = out_dat;
  assign m_if.m_chan  = out_chan;
  assign m_if.m_last  = out_last;
  assign m_if.m_valid = out_vld;

endmodule
